// File: rtl/nn_axis_result_tx.sv
// ---------------------------------------------------------------------------
// nn_axis_result_tx
//   AXI-Stream master for final-layer inference results. It captures one
//   NUM_OUT x DATA_WIDTH vector on a din_vld pulse into a two-slot buffer.
//   It then sends each vector as a frame of NUM_OUT sign-extended beats,
//   with full tready backpressure.
//
// Ports
//   s_axi_aclk      clock
//   s_axi_aresetn   async active-low reset
//   soft_reset      sync clear, same effect as reset
//   din / din_vld   parallel output vector (neuron 0 in LSBs), 1-cycle pulse
//   m_axis_*        AXI-Stream master (tdata, tvalid, tready, tlast)
//   busy            buffer non-empty or beat pending
//   overflow        sticky: a vector was dropped because the buffer was full
//   frame_count     frames fully sent (wraps)
// ---------------------------------------------------------------------------
module nn_axis_result_tx #(
    parameter int NUM_OUT     = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int TDATA_WIDTH = 32
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic                          soft_reset,
    input  logic [NUM_OUT*DATA_WIDTH-1:0] din,
    input  logic                          din_vld,
    output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          busy,
    output logic                          overflow,
    output logic [31:0]                   frame_count
);

    localparam int             BW        = $clog2(NUM_OUT);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(NUM_OUT - 1);

    typedef logic [NUM_OUT-1:0][DATA_WIDTH-1:0] vec_t;
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                 state, state_nxt;
    vec_t                   slot [2];
    vec_t                   din_v;
    logic                   wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [1:0]             occ, occ_nxt;
    logic [BW-1:0]          beat_idx, beat_nxt;
    logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                   tlast_q, tlast_d;
    logic                   busy_q, busy_d;
    logic                   ovf_q;
    logic [31:0]            fcnt_q;

    logic                   xfer, last_xfer, accept, drop;
    vec_t                   src_vec;
    logic [DATA_WIDTH-1:0]  beat_val;
    logic [TDATA_WIDTH-1:0] beat_ext;

    assign din_v = din;

    // ---------------- handshake / buffer bookkeeping ----------------
    assign xfer      = (state == SEND) & m_axis_tready;
    assign last_xfer = xfer & (beat_idx == LAST_BEAT);
    // When the buffer is full, the final-beat handshake frees the slot being
    // read. That slot is the one wr_ptr points at, so the write can land this cycle.
    assign accept    = din_vld & ((occ != 2'd2) | last_xfer);
    assign drop      = din_vld & ~accept;

    always_comb begin
        occ_nxt = occ;
        case ({accept, last_xfer})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
    end

    assign rd_ptr_nxt = rd_ptr ^ last_xfer;

    always_comb begin
        beat_nxt = beat_idx;
        if (last_xfer)
            beat_nxt = '0;
        else if (xfer)
            beat_nxt = beat_idx + 1'b1;
    end

    // The slot to be presented next may be the one being written this cycle.
    // This happens with an empty buffer, or when a frame ends just as the
    // next vector arrives. Bypass din so beat 0 appears one cycle after din_vld.
    assign src_vec  = (accept && (wr_ptr == rd_ptr_nxt)) ? din_v : slot[rd_ptr_nxt];
    assign beat_val = src_vec[beat_nxt];

    generate
        if (TDATA_WIDTH > DATA_WIDTH) begin : g_sext
            assign beat_ext = {{(TDATA_WIDTH-DATA_WIDTH){beat_val[DATA_WIDTH-1]}}, beat_val};
        end else begin : g_pass
            assign beat_ext = beat_val;
        end
    endgenerate

    // ---------------- FSM: state register ----------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn)
            state <= IDLE;
        else if (soft_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (occ_nxt != 2'd0) state_nxt = SEND;
            SEND: if (last_xfer && (occ_nxt == 2'd0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (next-cycle values, registered below) ----------------
    // Stall cycles recompute the same slot/beat, so tdata/tlast hold stable.
    always_comb begin
        tdata_d = '0;
        tlast_d = 1'b0;
        if (state_nxt == SEND) begin
            tdata_d = beat_ext;
            tlast_d = (beat_nxt == LAST_BEAT);
        end
        busy_d = (occ_nxt != 2'd0) | (state_nxt == SEND);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
            beat_idx <= '0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            fcnt_q   <= '0;
        end else if (soft_reset) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
            beat_idx <= '0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            wr_ptr   <= wr_ptr ^ accept;
            rd_ptr   <= rd_ptr_nxt;
            occ      <= occ_nxt;
            beat_idx <= beat_nxt;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_q | drop;
            fcnt_q   <= fcnt_q + 32'(last_xfer);
        end
    end

    // Slot contents need no reset; occupancy gates every read.
    always_ff @(posedge s_axi_aclk) begin
        if (accept && !soft_reset)
            slot[wr_ptr] <= din_v;
    end

    assign m_axis_tvalid = (state == SEND);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign overflow      = ovf_q;
    assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_nn_axis_result_tx.sv
module tb_nn_axis_result_tx;

    localparam int NO = 4;
    localparam int DW = 8;
    localparam int TW = 32;

    logic              clk;
    logic              rst_n;
    logic              soft_reset;
    logic [NO*DW-1:0]  din;
    logic              din_vld;
    logic [TW-1:0]     tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              busy;
    logic              overflow;
    logic [31:0]       frame_count;

    int tests  = 0;
    int errors = 0;

    nn_axis_result_tx #(.NUM_OUT(NO), .DATA_WIDTH(DW), .TDATA_WIDTH(TW)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .soft_reset    (soft_reset),
        .din           (din),
        .din_vld       (din_vld),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .busy          (busy),
        .overflow      (overflow),
        .frame_count   (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vectors, neuron3..neuron0
    localparam logic [31:0] VA = 32'h7F8001FF; // beats FFFFFFFF 00000001 FFFFFF80 0000007F
    localparam logic [31:0] VB = 32'h007E8110; // beats 00000010 FFFFFF81 0000007E 00000000
    localparam logic [31:0] VC = 32'h11223344; // beats 00000044 00000033 00000022 00000011

    // One record per cycle: inputs applied this cycle, outputs expected
    // during this cycle (i.e. produced by earlier edges).
    typedef struct {
        logic        vld;
        logic [31:0] din;
        logic        rdy;
        logic        srst;
        logic        tv;
        logic [31:0] data;
        logic        tl;
        logic        ov;
        logic [31:0] fc;
    } row_t;

    row_t tbl[$];

    function automatic void r(input logic vld, input logic [31:0] d, input logic rdy,
                              input logic srst, input logic tv, input logic [31:0] data,
                              input logic tl, input logic ov, input logic [31:0] fc);
        row_t x;
        x.vld = vld; x.din = d; x.rdy = rdy; x.srst = srst;
        x.tv = tv; x.data = data; x.tl = tl; x.ov = ov; x.fc = fc;
        tbl.push_back(x);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            din_vld    = tbl[i].vld;
            din        = tbl[i].din;
            tready     = tbl[i].rdy;
            soft_reset = tbl[i].srst;
            chk("tvalid", i, 32'(tvalid), 32'(tbl[i].tv));
            chk("busy", i, 32'(busy), 32'(tbl[i].tv));
            chk("overflow", i, 32'(overflow), 32'(tbl[i].ov));
            chk("frame_count", i, frame_count, tbl[i].fc);
            if (tbl[i].tv) begin
                chk("tdata", i, tdata, tbl[i].data);
                chk("tlast", i, 32'(tlast), 32'(tbl[i].tl));
            end
        end
    endtask

    int sec1_end;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- section 1 ----
        // single frame, tready=1 (also checks reset state on first row)
        r(1,VA,1,0, 0,0,0,0,0);
        r(0,0,1,0, 1,32'hFFFFFFFF,0,0,0);
        r(0,0,1,0, 1,32'h00000001,0,0,0);
        r(0,0,1,0, 1,32'hFFFFFF80,0,0,0);
        r(0,0,1,0, 1,32'h0000007F,1,0,0);
        // tready pattern 1,0,0,1,0,1,1
        r(1,VA,0,0, 0,0,0,0,1);
        r(0,0,1,0, 1,32'hFFFFFFFF,0,0,1);
        r(0,0,0,0, 1,32'h00000001,0,0,1);
        r(0,0,0,0, 1,32'h00000001,0,0,1);
        r(0,0,1,0, 1,32'h00000001,0,0,1);
        r(0,0,0,0, 1,32'hFFFFFF80,0,0,1);
        r(0,0,1,0, 1,32'hFFFFFF80,0,0,1);
        r(0,0,1,0, 1,32'h0000007F,1,0,1);
        // two pulses 2 cycles apart -> 8 contiguous beats
        r(1,VA,1,0, 0,0,0,0,2);
        r(0,0,1,0, 1,32'hFFFFFFFF,0,0,2);
        r(1,VB,1,0, 1,32'h00000001,0,0,2);
        r(0,0,1,0, 1,32'hFFFFFF80,0,0,2);
        r(0,0,1,0, 1,32'h0000007F,1,0,2);
        r(0,0,1,0, 1,32'h00000010,0,0,3);
        r(0,0,1,0, 1,32'hFFFFFF81,0,0,3);
        r(0,0,1,0, 1,32'h0000007E,0,0,3);
        r(0,0,1,0, 1,32'h00000000,1,0,3);
        // tready low, three pulses -> third dropped, overflow sticky
        r(1,VA,0,0, 0,0,0,0,4);
        r(0,0,0,0, 1,32'hFFFFFFFF,0,0,4);
        r(1,VB,0,0, 1,32'hFFFFFFFF,0,0,4);
        r(0,0,0,0, 1,32'hFFFFFFFF,0,0,4);
        r(1,VC,0,0, 1,32'hFFFFFFFF,0,0,4);
        r(0,0,0,0, 1,32'hFFFFFFFF,0,1,4);
        r(0,0,1,0, 1,32'hFFFFFFFF,0,1,4);
        r(0,0,1,0, 1,32'h00000001,0,1,4);
        r(0,0,1,0, 1,32'hFFFFFF80,0,1,4);
        r(0,0,1,0, 1,32'h0000007F,1,1,4);
        r(0,0,1,0, 1,32'h00000010,0,1,5);
        r(0,0,1,0, 1,32'hFFFFFF81,0,1,5);
        r(0,0,1,0, 1,32'h0000007E,0,1,5);
        r(0,0,1,0, 1,32'h00000000,1,1,5);
        r(0,0,1,1, 0,0,0,1,6);              // soft reset while idle
        // full buffer, capture on last-beat handshake of frame 1
        r(1,VA,0,0, 0,0,0,0,0);
        r(1,VB,0,0, 1,32'hFFFFFFFF,0,0,0);
        r(0,0,1,0, 1,32'hFFFFFFFF,0,0,0);
        r(0,0,1,0, 1,32'h00000001,0,0,0);
        r(0,0,1,0, 1,32'hFFFFFF80,0,0,0);
        r(1,VC,1,0, 1,32'h0000007F,1,0,0);
        r(0,0,1,0, 1,32'h00000010,0,0,1);
        r(0,0,1,0, 1,32'hFFFFFF81,0,0,1);
        r(0,0,1,0, 1,32'h0000007E,0,0,1);
        r(0,0,1,0, 1,32'h00000000,1,0,1);
        r(0,0,1,0, 1,32'h00000044,0,0,2);
        r(0,0,1,0, 1,32'h00000033,0,0,2);
        r(0,0,1,0, 1,32'h00000022,0,0,2);
        r(0,0,1,0, 1,32'h00000011,1,0,2);
        r(0,0,1,0, 0,0,0,0,3);
        sec1_end = tbl.size();
        // ---- section 2: after async reset ----
        r(1,VA,1,0, 0,0,0,0,0);
        r(0,0,1,0, 1,32'hFFFFFFFF,0,0,0);
        r(0,0,1,0, 1,32'h00000001,0,0,0);
        r(0,0,1,0, 1,32'hFFFFFF80,0,0,0);
        r(0,0,1,0, 1,32'h0000007F,1,0,0);
        // soft reset mid-frame with tready low: tvalid drops without handshake
        r(1,VA,1,0, 0,0,0,0,1);
        r(0,0,1,0, 1,32'hFFFFFFFF,0,0,1);
        r(0,0,1,0, 1,32'h00000001,0,0,1);
        r(0,0,0,1, 1,32'hFFFFFF80,0,0,1);
        r(1,VC,1,0, 0,0,0,0,0);
        r(0,0,1,0, 1,32'h00000044,0,0,0);
        r(0,0,1,0, 1,32'h00000033,0,0,0);
        r(0,0,1,0, 1,32'h00000022,0,0,0);
        r(0,0,1,0, 1,32'h00000011,1,0,0);
        r(0,0,1,0, 0,0,0,0,1);

        rst_n = 1'b0; soft_reset = 1'b0; din = '0; din_vld = 1'b0; tready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(0, sec1_end - 1);

        // async reset after beat 2 has been handshaken
        @(negedge clk);
        din_vld = 1'b1; din = VA; tready = 1'b1;
        chk("ar_idle_fc", -1, frame_count, 32'd3);
        @(negedge clk);
        din_vld = 1'b0;
        chk("ar_beat0", -1, tdata, 32'hFFFFFFFF);
        @(negedge clk);
        chk("ar_beat1", -1, tdata, 32'h00000001);
        @(negedge clk);
        chk("ar_beat2", -1, tdata, 32'hFFFFFF80);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_tvalid", -1, 32'(tvalid), 32'd0);
        chk("ar_tdata", -1, tdata, 32'd0);
        chk("ar_tlast", -1, 32'(tlast), 32'd0);
        chk("ar_busy", -1, 32'(busy), 32'd0);
        chk("ar_fc", -1, frame_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(sec1_end, tbl.size() - 1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/nn_axis_result_tx.md
Name: nn_axis_result_tx

Overview:
AXI-Stream master that sends inference results out of the NN core, opposite in direction to the core's AXI-Stream input. It captures one parallel output vector from the final layer on a one-cycle valid pulse. It buffers up to two vectors and serializes each as a frame of NUM_OUT beats on m_axis. Unlike the inter-layer serializers, it honours full tready backpressure.

Parameters:
NUM_OUT, 10, neurons in final layer = beats per frame (>=2)
DATA_WIDTH, 16, width of each neuron output (two's complement)
TDATA_WIDTH, 32, m_axis_tdata width (>= DATA_WIDTH)

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  asynchronous active-low reset
soft_reset  in  1  synchronous clear, active-high, same effect as reset
din  in  NUM_OUT*DATA_WIDTH  output vector; neuron 0 in bits [DATA_WIDTH-1:0]
din_vld  in  1  one-cycle pulse, din valid
m_axis_tdata  out  TDATA_WIDTH  sign-extended neuron value
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  sink ready
m_axis_tlast  out  1  high on beat NUM_OUT-1 of each frame
busy  out  1  buffer non-empty or beat pending
overflow  out  1  sticky: a vector was dropped
frame_count  out  32  frames fully sent, wraps at 2^32

Behaviour:
- Reset (async assert, sync deassert assumed upstream) or soft_reset: tvalid=0, tlast=0, tdata=0, busy=0, overflow=0, frame_count=0, buffer empty, beat index=0.
- Buffer: 2 slots, wr_ptr/rd_ptr 1 bit each, occupancy 0..2.
- Capture: din_vld with occupancy<2 writes din into slot[wr_ptr] and toggles wr_ptr.
- Capture when full: din_vld with occupancy=2 is accepted only if the final beat of the current frame is handshaking that cycle, because that handshake frees a slot. Otherwise the vector is dropped, overflow is set, and buffer and stream are unaffected.
- Occupancy update covers simultaneous capture + frame completion: net 0.
- Handshake: a beat transfers when tvalid&tready. Once tvalid=1, tdata/tlast are held stable until the transfer. tvalid never depends combinationally on tready. All outputs are registered.
- States:
  - IDLE: tvalid=0. Moves to SEND the cycle after occupancy becomes >=1.
  - SEND: presents slot[rd_ptr] beat beat_idx.
    - On transfer with beat_idx<NUM_OUT-1: beat_idx++ and the next beat is presented the next cycle.
    - On transfer with beat_idx=NUM_OUT-1: rd_ptr toggles, beat_idx=0, frame_count++, occupancy--. If another slot is full (including one captured that same cycle), stay in SEND and present its beat 0 next cycle with no bubble; otherwise go to IDLE with tvalid=0.
- Latency: din_vld at cycle N into an empty buffer gives tvalid=1 with beat 0 at N+1.
- Throughput: 1 beat/cycle with tready=1, back-to-back frames included.
- tdata = sign-extend(din slice) to TDATA_WIDTH. If TDATA_WIDTH==DATA_WIDTH, it is a pass-through.
- tlast = (beat_idx==NUM_OUT-1) while tvalid.
- busy = (occupancy!=0) | tvalid.
- soft_reset mid-frame: tvalid drops the next cycle even without a handshake. This deliberate exception to the AXI hold rule matches core soft reset. The partial frame is discarded and frame_count is not incremented.
- frame_count: 0xFFFFFFFF +1 wraps to 0; no flag.
- tready held low indefinitely: a captured slot remains and further vectors fill the second slot, then overflow. No data corruption.

Test Plan:
- NUM_OUT=4, DATA_WIDTH=8, TDATA_WIDTH=32, tready=1. din={0x7F,0x80,0x01,0xFF} (neuron3..0), one din_vld pulse -> tvalid from next cycle for 4 consecutive cycles. tdata = 0xFFFFFFFF, 0x00000001, 0xFFFFFF80, 0x0000007F. tlast only on 4th beat. frame_count=1, busy=0 after.
- Same vector, tready toggling 1,0,0,1,0,1,1 -> beats delivered in order with no duplication or loss. tdata/tlast stable during each tready=0 stall. Frame completes on the 4th handshake.
- Two din_vld pulses 2 cycles apart, tready=1 -> 8 contiguous beats, no bubble between frames, tlast on beats 4 and 8, frame_count=2.
- tready=0, three din_vld pulses -> first two held, overflow=1 after the third. Releasing tready emits exactly 2 frames, carrying vectors 1 and 2.
- Buffer full, din_vld in the same cycle as the last-beat handshake of frame 1 -> vector accepted, overflow stays 0, 3 frames total emitted.
- Assert s_axi_aresetn low after beat 2 of a frame -> outputs clear immediately (tvalid=0, frame_count=0). After release, a new vector gives a clean 4-beat frame starting at neuron 0. Repeat with soft_reset: clear takes effect on the next clock edge.
